// File: rtl/alignment_scheduler_pkg.sv
// Purpose : shared types and constants for the strip wavefront scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: score-source select codes, letters per block, FSM state type,
//           and the block-coordinate type used by the default build.
package alignment_scheduler_pkg;

  // Each PU consumes this many query and this many database letters per block.
  localparam int NUM_LETTERS_TO_CHOOSE = 2;

  // Score source select codes shared by the top/left/diagonal muxes.
  // ZERO must stay 2'd0 so that cleared registers and idle cycles read as
  // "no source".
  localparam logic [1:0] SEL_ZERO  = 2'd0;  // constant zero (matrix border)
  localparam logic [1:0] SEL_SELF  = 2'd1;  // own PU, previous step
  localparam logic [1:0] SEL_UPPER = 2'd2;  // PU one block-row up

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // Block coordinate for the default configuration (4 PUs, 16 letters):
  // signed and one bit wider than the step counter so s - r can go negative.
  localparam int DEF_NUM_PU     = 4;
  localparam int DEF_SEQ_LENGTH = 16;
  localparam int DEF_STEP_W     = $clog2(DEF_SEQ_LENGTH / 2 + DEF_NUM_PU);
  typedef logic signed [DEF_STEP_W:0] blk_coord_t;

endpackage

// File: rtl/alignment_sched_pu_map.sv
// Purpose : per-PU map from (step, block-row, nb) to block-valid, letter
//           indices and top/left/diagonal score source selects.
// Latency : combinational.
// Backpressure: none; the schedule never stalls.
// Ports   : active (scheduler in RUN), step, row, nb in;
//           valid, query_sel, database_sel, top_sel, left_sel, diag_sel out.
module alignment_sched_pu_map
  import alignment_scheduler_pkg::*;
#(
  parameter int STEP_W = 4,
  parameter int NB_W   = 4,
  parameter int LW     = 4
) (
  input  logic                                      active,
  input  logic [STEP_W-1:0]                         step,
  input  logic [STEP_W-1:0]                         row,
  input  logic [NB_W-1:0]                           nb,
  output logic                                      valid,
  output logic [NUM_LETTERS_TO_CHOOSE-1:0][LW-1:0]  query_sel,
  output logic [NUM_LETTERS_TO_CHOOSE-1:0][LW-1:0]  database_sel,
  output logic [1:0]                                top_sel,
  output logic [1:0]                                left_sel,
  output logic [1:0]                                diag_sel
);

  logic signed [STEP_W:0] col;
  logic signed [STEP_W:0] nb_s;

  // Column this PU works on at this step; negative before the wavefront
  // reaches its row.
  assign col  = $signed({1'b0, step}) - $signed({1'b0, row});
  assign nb_s = $signed({{(STEP_W + 1 - NB_W){1'b0}}, nb});

  assign valid = active && !col[STEP_W] && (col < nb_s);

  always_comb begin
    query_sel    = '0;
    database_sel = '0;
    top_sel      = SEL_ZERO;
    left_sel     = SEL_ZERO;
    diag_sel     = SEL_ZERO;
    if (active) begin
      query_sel[0] = LW'({row, 1'b0});
      query_sel[1] = LW'({row, 1'b1});
    end
    if (valid) begin
      // Range already checked, so truncating to the letter width is lossless.
      database_sel[0] = LW'({col[STEP_W-1:0], 1'b0});
      database_sel[1] = LW'({col[STEP_W-1:0], 1'b1});
      if (row != '0) top_sel = SEL_UPPER;
      if (col != '0) left_sel = SEL_SELF;
      if ((row != '0) && (col != '0)) diag_sel = SEL_UPPER;
    end
  end

endmodule

// File: rtl/alignment_scheduler.sv
// Purpose : wavefront controller sequencing the matrix datapath over one strip
//           (NUM_PU block-rows x cfg_db_blocks block-columns).
// Latency : busy one cycle after accepted start; RUN nb+NUM_PU-1 cycles,
//           then DRAIN and DONE (one cycle each); mem_wr_valid lags en_wr_pu by 1.
// Backpressure: none; start is only taken in IDLE, otherwise ignored.
// Ports   : clk, rst (sync, active-high), start, cfg_db_blocks in;
//           busy, done, cfg_err, top/left/diagonal_sel, query/database_letter_sel,
//           en_wr_pu, mem_wr_valid, step_idx out.
// Option  : ALIGN_SCHED_PERF_CNT_EN adds run_cycles[15:0] (accept..done
//           inclusive, saturating, held after done, cleared on accept).
module alignment_scheduler
  import alignment_scheduler_pkg::*;
#(
  parameter  int NUM_PU       = 4,
  parameter  int SEQ_LENGTH   = 16,
  parameter  int SEQ_LENGTH_W = $clog2(SEQ_LENGTH),
  parameter  int MAX_BLK      = SEQ_LENGTH / 2,
  localparam int NB_W         = $clog2(MAX_BLK + 1),
  localparam int STEP_W       = $clog2(MAX_BLK + NUM_PU)
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          start,
  input  logic [NB_W-1:0]                                               cfg_db_blocks,
  output logic                                                          busy,
  output logic                                                          done,
  output logic                                                          cfg_err,
  output logic [NUM_PU-2:0][1:0]                                        top_sel,
  output logic [NUM_PU-2:0][1:0]                                        left_sel,
  output logic [NUM_PU-2:0][1:0]                                        diagonal_sel,
  output logic [NUM_PU-1:0][NUM_LETTERS_TO_CHOOSE-1:0][SEQ_LENGTH_W-1:0] query_letter_sel,
  output logic [NUM_PU-1:0][NUM_LETTERS_TO_CHOOSE-1:0][SEQ_LENGTH_W-1:0] database_letter_sel,
  output logic [NUM_PU-1:0]                                             en_wr_pu,
  output logic [NUM_PU-1:0]                                             mem_wr_valid,
  output logic [STEP_W-1:0]                                             step_idx
`ifdef ALIGN_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]                                                   run_cycles
`endif
);

  sched_state_t      state;
  logic [STEP_W-1:0] step;
  logic [NB_W-1:0]   nb;
  logic [STEP_W-1:0] last_step;
  logic              cfg_ok;
  logic              accept;
  logic              running;

  logic [NUM_PU-1:0][1:0] top_all;
  logic [NUM_PU-1:0][1:0] left_all;
  logic [NUM_PU-1:0][1:0] diag_all;

  assign cfg_ok  = (cfg_db_blocks != '0) && (cfg_db_blocks <= NB_W'(MAX_BLK));
  assign accept  = (state == ST_IDLE) && start && cfg_ok;
  assign running = (state == ST_RUN);

  // RUN covers steps 0 .. nb+NUM_PU-2.
  assign last_step = STEP_W'(nb) + STEP_W'(NUM_PU - 2);
  assign step_idx  = step;

  for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
    alignment_sched_pu_map #(
      .STEP_W (STEP_W),
      .NB_W   (NB_W),
      .LW     (SEQ_LENGTH_W)
    ) u_map (
      .active       (running),
      .step         (step),
      .row          (STEP_W'(NUM_PU - 1 - i)),
      .nb           (nb),
      .valid        (en_wr_pu[i]),
      .query_sel    (query_letter_sel[i]),
      .database_sel (database_letter_sel[i]),
      .top_sel      (top_all[i]),
      .left_sel     (left_all[i]),
      .diag_sel     (diag_all[i])
    );
  end

  // The top-row PU takes its scores from the strip boundary path outside this
  // block, so only the lower NUM_PU-1 PUs have source muxes to drive.
  assign top_sel      = top_all[NUM_PU-2:0];
  assign left_sel     = left_all[NUM_PU-2:0];
  assign diagonal_sel = diag_all[NUM_PU-2:0];

  logic unused_row0_sel;
  assign unused_row0_sel = ^{top_all[NUM_PU-1], left_all[NUM_PU-1], diag_all[NUM_PU-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      step         <= '0;
      nb           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      mem_wr_valid <= '0;
    end else begin
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      // Write data leaves the PUs through a register stage; keep the
      // valids aligned with it.
      mem_wr_valid <= en_wr_pu;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              nb    <= cfg_db_blocks;
              step  <= '0;
              busy  <= 1'b1;
              state <= ST_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (step == last_step) begin
            step  <= '0;
            state <= ST_DRAIN;
          end else begin
            step <= step + 1'b1;
          end
        end
        ST_DRAIN: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALIGN_SCHED_PERF_CNT_EN
  // Loaded with 2 at accept: the accept cycle plus the first RUN cycle in
  // which the value becomes visible. Held during DONE so it reads the total.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (accept) begin
      run_cycles <= 16'd2;
    end else if (((state == ST_RUN) || (state == ST_DRAIN)) && (run_cycles != 16'hFFFF)) begin
      run_cycles <= run_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alignment_scheduler.sv
module tb_alignment_scheduler;

  localparam int NUM_PU     = 4;
  localparam int SEQ_LENGTH = 16;
  localparam int LW         = 4;
  localparam int MAX_BLK    = 8;
  localparam int NB_W       = 4;
  localparam int STEP_W     = 4;

  localparam logic [1:0] C_ZERO  = 2'd0;
  localparam logic [1:0] C_SELF  = 2'd1;
  localparam logic [1:0] C_UPPER = 2'd2;

  logic clk;
  logic rst;
  logic start;
  logic [NB_W-1:0] cfg_db_blocks;
  logic busy, done, cfg_err;
  logic [NUM_PU-2:0][1:0] top_sel, left_sel, diagonal_sel;
  logic [NUM_PU-1:0][1:0][LW-1:0] query_letter_sel, database_letter_sel;
  logic [NUM_PU-1:0] en_wr_pu, mem_wr_valid;
  logic [STEP_W-1:0] step_idx;
`ifdef ALIGN_SCHED_PERF_CNT_EN
  logic [15:0] run_cycles;
`endif

  int n_checks = 0;
  int n_err    = 0;

  alignment_scheduler #(.NUM_PU(NUM_PU), .SEQ_LENGTH(SEQ_LENGTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .cfg_db_blocks       (cfg_db_blocks),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
    .top_sel             (top_sel),
    .left_sel            (left_sel),
    .diagonal_sel        (diagonal_sel),
    .query_letter_sel    (query_letter_sel),
    .database_letter_sel (database_letter_sel),
    .en_wr_pu            (en_wr_pu),
    .mem_wr_valid        (mem_wr_valid),
    .step_idx            (step_idx)
`ifdef ALIGN_SCHED_PERF_CNT_EN
    ,
    .run_cycles          (run_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // A run is described only by the cycle index k since accept (k=1 is the
  // first cycle with busy high). Cycles 1..S are steps 0..S-1, S+1 is the
  // drain cycle and S+2 carries the done pulse, with S = nb+NUM_PU-1.
  bit m_live   = 1'b0;
  bit m_active = 1'b0;
  bit m_err    = 1'b0;
  int m_k      = 0;
  int m_nb     = 0;
  int m_rc     = 0;
  logic [NUM_PU-1:0] m_prev_en = '0;

  function automatic logic [NUM_PU-1:0] model_en(input bit act, input int k, input int nbv);
    model_en = '0;
    if (act && k >= 1 && k <= nbv + NUM_PU - 1) begin
      for (int i = 0; i < NUM_PU; i++) begin
        int c;
        c = (k - 1) - (NUM_PU - 1 - i);
        if (c >= 0 && c < nbv) model_en[i] = 1'b1;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live    <= 1'b1;
      m_active  <= 1'b0;
      m_err     <= 1'b0;
      m_k       <= 0;
      m_rc      <= 0;
      m_prev_en <= '0;
    end else if (m_live) begin
      m_err     <= 1'b0;
      m_prev_en <= model_en(m_active, m_k, m_nb);
      if (!m_active) begin
        if (start) begin
          if (int'(cfg_db_blocks) >= 1 && int'(cfg_db_blocks) <= MAX_BLK) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_nb     <= int'(cfg_db_blocks);
            m_rc     <= 2;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (m_k == m_nb + NUM_PU + 1) begin
        m_active <= 1'b0;
      end else begin
        m_k  <= m_k + 1;
        m_rc <= (m_rc < 65535) ? m_rc + 1 : m_rc;
      end
    end
  end

  always @(negedge clk) begin : cmp_blk
    logic [NUM_PU-1:0] e_en;
    logic [NUM_PU-1:0][1:0][LW-1:0] e_q, e_d;
    logic [NUM_PU-2:0][1:0] e_top, e_left, e_diag;
    int s_len, s, c;
    bit run;
    if (m_live) begin
      e_q = '0; e_d = '0; e_top = '0; e_left = '0; e_diag = '0;
      s_len = m_nb + NUM_PU - 1;
      run   = m_active && m_k >= 1 && m_k <= s_len;
      s     = m_k - 1;
      e_en  = model_en(m_active, m_k, m_nb);
      for (int i = 0; i < NUM_PU; i++) begin
        c = s - (NUM_PU - 1 - i);
        if (run) begin
          e_q[i][0] = LW'(2 * (NUM_PU - 1 - i));
          e_q[i][1] = LW'(2 * (NUM_PU - 1 - i) + 1);
        end
        if (e_en[i]) begin
          e_d[i][0] = LW'(2 * c);
          e_d[i][1] = LW'(2 * c + 1);
        end
      end
      for (int i = 0; i < NUM_PU - 1; i++) begin
        c = s - (NUM_PU - 1 - i);
        if (e_en[i]) begin
          e_top[i] = C_UPPER;
          if (c != 0) begin
            e_left[i] = C_SELF;
            e_diag[i] = C_UPPER;
          end
        end
      end
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_active && m_k == s_len + 2));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      chk("step_idx", 64'(step_idx), run ? 64'(s) : 64'(0));
      chk("en_wr_pu", 64'(en_wr_pu), 64'(e_en));
      chk("mem_wr_valid", 64'(mem_wr_valid), 64'(m_prev_en));
      chk("query_letter_sel", 64'(query_letter_sel), 64'(e_q));
      chk("database_letter_sel", 64'(database_letter_sel), 64'(e_d));
      chk("top_sel", 64'(top_sel), 64'(e_top));
      chk("left_sel", 64'(left_sel), 64'(e_left));
      chk("diagonal_sel", 64'(diagonal_sel), 64'(e_diag));
`ifdef ALIGN_SCHED_PERF_CNT_EN
      chk("run_cycles", 64'(run_cycles), 64'(m_rc));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic launch(input int nbv);
    start = 1'b1;
    cfg_db_blocks = NB_W'(nbv);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int nbusy, ndone, sel;
    rst = 1'b1;
    start = 1'b0;
    cfg_db_blocks = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_en", 64'(en_wr_pu), 64'(0));
    chk("rst_mwv", 64'(mem_wr_valid), 64'(0));
    chk("rst_step", 64'(step_idx), 64'(0));
    rst = 1'b0;
    tick();

    // 1: nb=8 full run
    launch(8);
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_s0_en", 64'(en_wr_pu), 64'(4'b1000));
    chk("t1_s0_db3", 64'(database_letter_sel[3]), 64'(8'h10));
    repeat (10) tick();
    chk("t1_s10_step", 64'(step_idx), 64'(10));
    chk("t1_s10_en", 64'(en_wr_pu), 64'(4'b0001));
    chk("t1_s10_db0", 64'(database_letter_sel[0]), 64'(8'hFE));
    tick();
    chk("t1_drain_en", 64'(en_wr_pu), 64'(0));
    chk("t1_drain_mwv", 64'(mem_wr_valid), 64'(4'b0001));
    chk("t1_drain_done", 64'(done), 64'(0));
    tick();
    chk("t1_done", 64'(done), 64'(1));
    tick();
    chk("t1_idle_busy", 64'(busy), 64'(0));

    // 2: select codes at nb=2 step 2
    launch(2);
    repeat (2) tick();
    chk("t2_top2", 64'(top_sel[2]), 64'(C_UPPER));
    chk("t2_left2", 64'(left_sel[2]), 64'(C_SELF));
    chk("t2_diag2", 64'(diagonal_sel[2]), 64'(C_UPPER));
    chk("t2_left1", 64'(left_sel[1]), 64'(C_ZERO));
    chk("t2_diag1", 64'(diagonal_sel[1]), 64'(C_ZERO));
    wait_idle(20);

    // 3: rejected configurations
    for (int v = 0; v < 2; v++) begin
      launch(v == 0 ? 0 : 9);
      chk("t3_err", 64'(cfg_err), 64'(1));
      chk("t3_busy", 64'(busy), 64'(0));
      chk("t3_sels", 64'({top_sel, left_sel, diagonal_sel}), 64'(0));
      tick();
      chk("t3_err_pulse", 64'(cfg_err), 64'(0));
    end

    // 4: start held high across a run
    start = 1'b1;
    cfg_db_blocks = 4'd1;
    tick();
    nbusy = 0;
    ndone = 0;
    while (busy === 1'b1 && nbusy < 50) begin
      if (done === 1'b1) ndone++;
      nbusy++;
      tick();
    end
    chk("t4_busy_cycles", 64'(nbusy), 64'(6));
    chk("t4_done_pulses", 64'(ndone), 64'(1));
    tick();
    chk("t4_reaccept", 64'(busy), 64'(1));
    start = 1'b0;
    wait_idle(20);

    // 5: reset at step 5, then a fresh run
    launch(8);
    repeat (5) tick();
    chk("t5_step5", 64'(step_idx), 64'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_en_mwv", 64'({en_wr_pu, mem_wr_valid}), 64'(0));
    chk("t5_letters", 64'({query_letter_sel, database_letter_sel}), 64'(0));
    chk("t5_sels_step", 64'({top_sel, left_sel, diagonal_sel, step_idx}), 64'(0));
    launch(3);
    nbusy = 0;
    ndone = 0;
    while (busy === 1'b1 && nbusy < 50) begin
      if (done === 1'b1) ndone++;
      nbusy++;
      tick();
    end
    chk("t5_rerun_cycles", 64'(nbusy), 64'(8));
    chk("t5_rerun_done", 64'(ndone), 64'(1));

`ifdef ALIGN_SCHED_PERF_CNT_EN
    // 6: cycle counter for nb=1
    launch(1);
    nbusy = 0;
    while (done !== 1'b1 && nbusy < 20) begin
      tick();
      nbusy++;
    end
    chk("t6_rc_done", 64'(run_cycles), 64'(7));
    repeat (3) tick();
    chk("t6_rc_hold", 64'(run_cycles), 64'(7));
`endif

    // random traffic against the model
    for (int it = 0; it < 600; it++) begin
      sel = $urandom_range(0, 99);
      rst = (sel < 2);
      start = (sel >= 2 && sel < 55);
      cfg_db_blocks = (sel < 45) ? NB_W'($urandom_range(1, MAX_BLK)) : NB_W'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    wait_idle(40);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
